// File: rtl/pc_ir_datapath.sv
// rtl/pc_ir_datapath.sv - PC, IR, MDR and ALUOut registers with instruction field decode
// Optional branch statistics counters are enabled by defining BRANCH_STATS_EN.
`timescale 1ns/1ps

module pc_ir_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic [1:0]       PCSrc,
    input  logic             IRWrite,
    input  logic             Zero,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic [5:0]       Opcode,
    output logic [5:0]       Funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [31:0]      imm_sext,
    output logic [31:0]      imm_shl2,
    output logic [31:0]      mdr,
    output logic [31:0]      alu_out,
`ifdef BRANCH_STATS_EN
    output logic             misalign,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_not_taken_cnt
`else
    output logic             misalign
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $fatal(1, "CNT_W must be at least 1");
    end

    logic [31:0] target;
    logic        pc_en;

    always_comb begin
        target = alu_result;
        case (PCSrc)
            2'b00:   target = alu_result;
            2'b01:   target = alu_out;
            2'b10:   target = {pc[31:28], instr[25:0], 2'b00};
            default: target = rs_data;
        endcase
    end

    assign pc_en = PCWrite | (Branch & Zero);

    // Misaligned targets are silently truncated; misalign only flags the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= 32'h0;
            mdr      <= 32'h0;
            alu_out  <= 32'h0;
            misalign <= 1'b0;
        end else begin
            alu_out  <= alu_result;
            mdr      <= mem_rdata;
            if (IRWrite) begin
                instr <= mem_rdata;
            end
            if (pc_en) begin
                pc <= {target[31:2], 2'b00};
            end
            misalign <= pc_en && (target[1:0] != 2'b00);
        end
    end

    assign Opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign Funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_shl2 = {imm_sext[29:0], 2'b00};

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Branches issued together with PCWrite are unconditional jumps, not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt     <= '0;
            br_not_taken_cnt <= '0;
        end else if (Branch && !PCWrite) begin
            if (Zero) begin
                if (br_taken_cnt != CNT_MAX) begin
                    br_taken_cnt <= br_taken_cnt + CNT_ONE;
                end
            end else begin
                if (br_not_taken_cnt != CNT_MAX) begin
                    br_not_taken_cnt <= br_not_taken_cnt + CNT_ONE;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_ir_datapath.sv
// tb/tb_pc_ir_datapath.sv - scoreboard testbench for pc_ir_datapath
`timescale 1ns/1ps

module tb_pc_ir_datapath;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, Branch, IRWrite, Zero;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result, rs_data, mem_rdata;
    logic [31:0] pc, instr, imm_sext, imm_shl2, mdr, alu_out;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_taken_cnt, br_not_taken_cnt;
`endif

    pc_ir_datapath #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .Zero(Zero), .alu_result(alu_result), .rs_data(rs_data),
        .mem_rdata(mem_rdata), .pc(pc), .instr(instr), .Opcode(Opcode), .Funct(Funct),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm_sext(imm_sext), .imm_shl2(imm_shl2),
        .mdr(mdr), .alu_out(alu_out),
`ifdef BRANCH_STATS_EN
        .misalign(misalign), .br_taken_cnt(br_taken_cnt), .br_not_taken_cnt(br_not_taken_cnt)
`else
        .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    // Packed state {pc, instr, mdr, alu_out, misalign}
    typedef logic [128:0] st_t;
    st_t sb[$];
    st_t e;
    int  n_cmp = 0;
    int  n_fail = 0;

    logic [31:0] m_pc, m_ir, m_mdr, m_alu_out;

    function automatic st_t dut_st();
        return {pc, instr, mdr, alu_out, misalign};
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_ir = 32'h0; m_mdr = 32'h0; m_alu_out = 32'h0;
        sb.delete();
    endtask

    // Drive one cycle, push the model's prediction, return #1 after the edge.
    task automatic step(input logic pcw, input logic br, input logic [1:0] src,
                        input logic irw, input logic z, input logic [31:0] ar,
                        input logic [31:0] rsd, input logic [31:0] mem);
        logic [31:0] tgt;
        logic        en, mis;
        case (src)
            2'b00:   tgt = ar;
            2'b01:   tgt = m_alu_out;
            2'b10:   tgt = {m_pc[31:28], m_ir[25:0], 2'b00};
            default: tgt = rsd;
        endcase
        en  = pcw | (br & z);
        mis = en && (tgt[1:0] != 2'b00);
        if (en)  m_pc = {tgt[31:2], 2'b00};
        if (irw) m_ir = mem;
        m_mdr = mem;
        m_alu_out = ar;
        sb.push_back({m_pc, m_ir, m_mdr, m_alu_out, mis});
        PCWrite = pcw; Branch = br; PCSrc = src; IRWrite = irw; Zero = z;
        alu_result = ar; rs_data = rsd; mem_rdata = mem;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        PCWrite = 0; Branch = 0; PCSrc = 0; IRWrite = 0; Zero = 0;
        alu_result = 0; rs_data = 0; mem_rdata = 0;
        model_reset();
        #12;
        n_cmp++;
        if (dut_st() !== {RESET_PC, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", dut_st(), {RESET_PC, 97'h0});
        end
        n_cmp++;
        if ({Opcode, Funct} !== 12'h0) begin
            n_fail++; $display("FAIL reset_decode: got %h want 000", {Opcode, Funct});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        step(1, 0, 2'b00, 1, 0, 32'd4, 32'h0, 32'h8C22_0004);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e) begin
            n_fail++; $display("FAIL fetch_state: got %h want %h", dut_st(), e);
        end
        n_cmp++;
        if ({pc, Opcode, rs, rt, imm_sext, imm_shl2} !== {32'd4, 6'h23, 5'd1, 5'd2, 32'd4, 32'd16}) begin
            n_fail++; $display("FAIL fetch_decode: got pc=%h op=%h rs=%0d rt=%0d imm=%h shl2=%h want pc=4 op=23 rs=1 rt=2 imm=4 shl2=10",
                               pc, Opcode, rs, rt, imm_sext, imm_shl2);
        end
    endtask

    task automatic test_decode();
        step(0, 0, 2'b00, 1, 0, 32'h0, 32'h0, 32'h0003_1140);
        e = sb.pop_front();
        n_cmp++;
        if ({Opcode, rs, rt, rd, shamt, Funct} !== {6'h0, 5'd0, 5'd3, 5'd2, 5'd5, 6'h0}) begin
            n_fail++; $display("FAIL decode_rtype: got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h want 0/0/3/2/5/0",
                               Opcode, rs, rt, rd, shamt, Funct);
        end
        step(0, 0, 2'b00, 1, 0, 32'h0, 32'h0, 32'h1043_FFFC);
        e = sb.pop_front();
        n_cmp++;
        if ({Opcode, rs, rt, imm_sext, imm_shl2} !== {6'h4, 5'd2, 5'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF0}) begin
            n_fail++; $display("FAIL decode_negimm: got op=%h rs=%0d rt=%0d imm=%h shl2=%h want 4/2/3/fffffffc/fffffff0",
                               Opcode, rs, rt, imm_sext, imm_shl2);
        end
        n_cmp++;
        if (dut_st() !== e) begin
            n_fail++; $display("FAIL decode_state: got %h want %h", dut_st(), e);
        end
    endtask

    task automatic test_branch();
        step(0, 0, 2'b00, 0, 0, 32'h40, 32'h0, 32'h0);
        e = sb.pop_front();
        step(0, 1, 2'b01, 0, 1, 32'h99, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || pc !== 32'h40) begin
            n_fail++; $display("FAIL beq_taken: got %h want %h", dut_st(), e);
        end
        step(0, 0, 2'b00, 0, 0, 32'h80, 32'h0, 32'h0);
        e = sb.pop_front();
        step(0, 1, 2'b01, 0, 0, 32'h0, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || pc !== 32'h40) begin
            n_fail++; $display("FAIL beq_not_taken: got %h want %h", dut_st(), e);
        end
    endtask

    task automatic test_jump();
        step(1, 0, 2'b00, 1, 0, 32'h1000_0008, 32'h0, 32'h0800_0010);
        e = sb.pop_front();
        step(1, 0, 2'b10, 0, 0, 32'h0, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || pc !== 32'h1000_0040) begin
            n_fail++; $display("FAIL jump: got %h want %h", dut_st(), e);
        end
        step(1, 0, 2'b11, 0, 0, 32'h0, 32'h123, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || {pc, misalign} !== {32'h120, 1'b1}) begin
            n_fail++; $display("FAIL jr_misalign: got %h want %h", dut_st(), e);
        end
        step(0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (misalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got %b want 0", misalign);
        end
    endtask

    task automatic test_simultaneous();
        step(1, 1, 2'b00, 0, 0, 32'h200, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || pc !== 32'h200) begin
            n_fail++; $display("FAIL pcwrite_overrides_zero: got %h want %h", dut_st(), e);
        end
        step(0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || mdr !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ir_hold_mdr_load: got %h want %h", dut_st(), e);
        end
        step(0, 1, 2'b00, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_st() !== e || pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL branch_truncate: got %h want %h", dut_st(), e);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 2'b00, 1, 0, 32'h300, 32'h0, 32'h1234_5678);
        e = sb.pop_front();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_st() !== {RESET_PC, 97'h0}) begin
            n_fail++; $display("FAIL reset_mid: got %h want %h", dut_st(), {RESET_PC, 97'h0});
        end
        #2;
        rst_n = 1'b1;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_branch_stats();
        test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b00, 0, 1, 32'h10, 32'h0, 32'h0);
            e = sb.pop_front();
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 2'b00, 0, 0, 32'h10, 32'h0, 32'h0);
            e = sb.pop_front();
        end
        step(1, 1, 2'b00, 0, 1, 32'h10, 32'h0, 32'h0);
        e = sb.pop_front();
        n_cmp++;
        if ({br_taken_cnt, br_not_taken_cnt} !== {16'd3, 16'd2}) begin
            n_fail++; $display("FAIL stats_counts: got %0d/%0d want 3/2", br_taken_cnt, br_not_taken_cnt);
        end
        PCWrite = 0; Branch = 1; Zero = 1;
        repeat (65535) @(posedge clk);
        #1;
        Branch = 0;
        n_cmp++;
        if ({br_taken_cnt, br_not_taken_cnt} !== {16'hFFFF, 16'd2}) begin
            n_fail++; $display("FAIL stats_saturate: got %h/%h want ffff/0002", br_taken_cnt, br_not_taken_cnt);
        end
    endtask
`endif

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_decode();
        test_branch();
        test_jump();
        test_simultaneous();
        test_reset_mid();
`ifdef BRANCH_STATS_EN
        test_branch_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
